// File: rtl/torreta_pkg.sv
// Shared definitions for the turret control units: FSM state codes, which
// double as the db_estado debug encoding.
package torreta_pkg;

  localparam int ESTADO_W = 3;

  typedef enum logic [ESTADO_W-1:0] {
    PARADO          = 3'd0,
    AGUARDA_POSICAO = 3'd1,
    CICLO           = 3'd2,
    AVANCA          = 3'd3,
    FALHA           = 3'd4
  } estado_t;

endpackage

// File: rtl/contador_acomodacao.sv
// Modulo-M servo settle timer: counts while conta=1, wraps after M-1 and
// flags that last count with a single-cycle fim.
module contador_acomodacao #(
  parameter int M = 4,
  parameter int W = $clog2(M + 1)
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  output logic fim
);

  localparam logic [W-1:0] ULTIMO = W'(M - 1);

  logic [W-1:0] r_valor;

  always_ff @(posedge clock) begin
    if (reset || zera) begin
      r_valor <= '0;
    end else if (conta) begin
      if (r_valor == ULTIMO) r_valor <= '0;
      else                   r_valor <= r_valor + W'(1);
    end
  end

  assign fim = conta && (r_valor == ULTIMO);

endmodule

// File: rtl/torreta_varredura_uc.sv
// Sweep scheduler above torreta_uc: ping-pong servo indexing with settle
// delay, consecutive-timeout fault detection and last-threat position latch.
module torreta_varredura_uc
  import torreta_pkg::*;
#(
  parameter int N_POS        = 8,
  parameter int POS_W        = 3,
  parameter int T_ACOMODA    = 25_000_000,
  parameter int MAX_TIMEOUTS = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ligar,
  input  logic             girar,
  input  logic             pronto_ciclo,
  input  logic             timeout_medicao,
  input  logic             ameaca_detectada,
  output logic             ligar_torreta,
  output logic [POS_W-1:0] posicao,
  output logic             direcao,
  output logic             falha,
  output logic [POS_W-1:0] ameaca_posicao,
  output logic             ameaca_valida,
  output logic [2:0]       db_estado
);

  localparam int TO_W = $clog2(MAX_TIMEOUTS + 1);

  localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(MAX_TIMEOUTS);
  localparam logic [POS_W-1:0] POS_ULT = POS_W'(N_POS - 1);
  localparam logic [POS_W-1:0] POS_PEN = POS_W'(N_POS - 2);
  localparam logic [POS_W-1:0] POS_UM  = POS_W'(1);

  estado_t          r_estado;
  logic [POS_W-1:0] r_posicao;
  logic             r_direcao;
  logic             r_falha;
  logic [POS_W-1:0] r_ameaca_posicao;
  logic             r_ameaca_valida;
  logic [TO_W-1:0]  r_n_timeouts;
  logic             r_teve_timeout;

  logic             w_fim;
  logic             w_zera;
  logic             w_conta;
  logic             w_ativo;
  logic [TO_W-1:0]  w_n_timeouts_inc;
  logic             w_falha_agora;

  function automatic logic [TO_W-1:0] inc_saturado(input logic [TO_W-1:0] n);
    return (n >= TO_MAX) ? TO_MAX : n + TO_W'(1);
  endfunction

  // Settle timer runs only while waiting; held at zero everywhere else so
  // every entry into AGUARDA_POSICAO starts from a cleared count.
  assign w_conta = (r_estado == AGUARDA_POSICAO);
  assign w_zera  = !ligar || (r_estado != AGUARDA_POSICAO);

  contador_acomodacao #(
    .M (T_ACOMODA)
  ) u_acomoda (
    .clock (clock),
    .reset (reset),
    .zera  (w_zera),
    .conta (w_conta),
    .fim   (w_fim)
  );

  assign w_ativo          = (r_estado != PARADO) && (r_estado != FALHA);
  assign w_n_timeouts_inc = inc_saturado(r_n_timeouts);
  assign w_falha_agora    = (r_estado == CICLO) && timeout_medicao &&
                            (w_n_timeouts_inc == TO_MAX);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado         <= PARADO;
      r_posicao        <= '0;
      r_direcao        <= 1'b0;
      r_falha          <= 1'b0;
      r_ameaca_posicao <= '0;
      r_ameaca_valida  <= 1'b0;
      r_n_timeouts     <= '0;
      r_teve_timeout   <= 1'b0;
    end else if (!ligar) begin
      // Position, direction and threat memory survive a disable.
      r_estado       <= PARADO;
      r_falha        <= 1'b0;
      r_n_timeouts   <= '0;
      r_teve_timeout <= 1'b0;
    end else begin
      if (w_ativo) begin
        // A pronto that closes a timed-out cycle must not reset the run of
        // consecutive timeouts; only a clean cycle does.
        if (timeout_medicao) begin
          r_n_timeouts   <= w_n_timeouts_inc;
          r_teve_timeout <= 1'b1;
        end else if (pronto_ciclo) begin
          if (!r_teve_timeout) r_n_timeouts <= '0;
          r_teve_timeout <= 1'b0;
        end
        if (pronto_ciclo && ameaca_detectada) begin
          r_ameaca_posicao <= r_posicao;
          r_ameaca_valida  <= 1'b1;
        end
      end

      case (r_estado)
        PARADO: r_estado <= AGUARDA_POSICAO;
        AGUARDA_POSICAO: begin
          if (w_fim) r_estado <= CICLO;
        end
        CICLO: begin
          if (w_falha_agora) begin
            r_estado <= FALHA;
            r_falha  <= 1'b1;
          end else if (girar) begin
            r_estado <= AVANCA;
          end
        end
        AVANCA: begin
          if (!r_direcao) begin
            if (r_posicao == POS_ULT) begin
              r_direcao <= 1'b1;
              r_posicao <= POS_PEN;
            end else begin
              r_posicao <= r_posicao + POS_UM;
            end
          end else begin
            if (r_posicao == '0) begin
              r_direcao <= 1'b0;
              r_posicao <= POS_UM;
            end else begin
              r_posicao <= r_posicao - POS_UM;
            end
          end
          r_estado <= AGUARDA_POSICAO;
        end
        FALHA:   r_estado <= FALHA;
        default: r_estado <= PARADO;
      endcase
    end
  end

  // AVANCA keeps torreta_uc enabled so the pronto following girar completes.
  assign ligar_torreta  = (r_estado == CICLO) || (r_estado == AVANCA);
  assign posicao        = r_posicao;
  assign direcao        = r_direcao;
  assign falha          = r_falha;
  assign ameaca_posicao = r_ameaca_posicao;
  assign ameaca_valida  = r_ameaca_valida;
  assign db_estado      = r_estado;

endmodule

// File: tb/tb_torreta_varredura_uc.sv
// Randomized bench for torreta_varredura_uc against a transaction-level model
// of the sweep: ping-pong index arithmetic, timeout run count, threat memory.
module tb_torreta_varredura_uc;

  localparam int N_POS = 4;
  localparam int POS_W = 2;
  localparam int T_AC  = 4;
  localparam int MAX_T = 3;
  localparam int PER   = 2 * N_POS - 2;

  logic             clock = 1'b0;
  logic             reset, ligar, girar, pronto_ciclo, timeout_medicao, ameaca_detectada;
  logic             ligar_torreta, direcao, falha, ameaca_valida;
  logic [POS_W-1:0] posicao, ameaca_posicao;
  logic [2:0]       db_estado;

  int n_vec = 0;
  int n_err = 0;

  // model state
  int m_idx = 0;
  int m_cnt = 0;
  bit m_teve = 0;
  int m_ap = 0;
  bit m_av = 0;

  always #5 clock = ~clock;

  torreta_varredura_uc #(
    .N_POS(N_POS), .POS_W(POS_W), .T_ACOMODA(T_AC), .MAX_TIMEOUTS(MAX_T)
  ) dut (
    .clock(clock), .reset(reset), .ligar(ligar), .girar(girar),
    .pronto_ciclo(pronto_ciclo), .timeout_medicao(timeout_medicao),
    .ameaca_detectada(ameaca_detectada), .ligar_torreta(ligar_torreta),
    .posicao(posicao), .direcao(direcao), .falha(falha),
    .ameaca_posicao(ameaca_posicao), .ameaca_valida(ameaca_valida),
    .db_estado(db_estado)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic int pp_pos(input int i);
    int p = i % PER;
    return (p < N_POS) ? p : PER - p;
  endfunction

  function automatic int pp_dir(input int i);
    int p = i % PER;
    return (i > 0 && (p == 0 || p >= N_POS)) ? 1 : 0;
  endfunction

  function automatic void m_pronto(input bit am);
    if (am) begin
      m_ap = pp_pos(m_idx);
      m_av = 1;
    end
    if (!m_teve) m_cnt = 0;
    m_teve = 0;
  endfunction

  function automatic bit m_timeout();
    m_cnt  = (m_cnt + 1 > MAX_T) ? MAX_T : m_cnt + 1;
    m_teve = 1;
    return (m_cnt == MAX_T);
  endfunction

  task automatic start_sweep();
    ligar = 1;
    tick();
    chk("start_estado", db_estado, 1);
    chk("start_lt", ligar_torreta, 0);
    repeat (T_AC - 1) begin
      tick();
      chk("settle_lt", ligar_torreta, 0);
    end
    tick();
    chk("ciclo_lt", ligar_torreta, 1);
    chk("ciclo_estado", db_estado, 2);
    chk("ciclo_pos", posicao, pp_pos(m_idx));
    chk("ciclo_dir", direcao, pp_dir(m_idx));
  endtask

  task automatic step(input bit fix, input bit to, input bit am, output bit fault);
    fault = 0;
    if (fix) begin
      pronto_ciclo = 1; ameaca_detectada = am;
      tick();
      pronto_ciclo = 0; ameaca_detectada = 0;
      m_pronto(am);
      chk("fixar_estado", db_estado, 2);
      chk("fixar_apos", ameaca_posicao, m_ap);
      chk("fixar_aval", ameaca_valida, m_av);
    end
    if (to) begin
      timeout_medicao = 1;
      tick();
      timeout_medicao = 0;
      if (m_timeout()) begin
        fault = 1;
        chk("falha_flag", falha, 1);
        chk("falha_estado", db_estado, 4);
        chk("falha_lt", ligar_torreta, 0);
        chk("falha_pos", posicao, pp_pos(m_idx));
        return;
      end
      chk("to_nofalha", falha, 0);
      chk("to_estado", db_estado, 2);
    end
    girar = 1;
    tick();
    girar = 0;
    chk("avanca_estado", db_estado, 3);
    chk("avanca_lt", ligar_torreta, 1);
    chk("avanca_pos", posicao, pp_pos(m_idx));
    pronto_ciclo = 1; ameaca_detectada = am;
    tick();
    pronto_ciclo = 0; ameaca_detectada = 0;
    m_pronto(am);
    m_idx++;
    chk("adv_pos", posicao, pp_pos(m_idx));
    chk("adv_dir", direcao, pp_dir(m_idx));
    chk("adv_estado", db_estado, 1);
    chk("adv_lt", ligar_torreta, 0);
    chk("adv_apos", ameaca_posicao, m_ap);
    chk("adv_aval", ameaca_valida, m_av);
    repeat (T_AC - 1) begin
      tick();
      chk("reset_lt", ligar_torreta, 0);
    end
    tick();
    chk("rearm_lt", ligar_torreta, 1);
    chk("rearm_estado", db_estado, 2);
    chk("nofalha", falha, 0);
  endtask

  task automatic disable_sweep();
    ligar = 0;
    tick();
    m_cnt = 0; m_teve = 0;
    chk("off_falha", falha, 0);
    chk("off_estado", db_estado, 0);
    chk("off_lt", ligar_torreta, 0);
    chk("off_pos", posicao, pp_pos(m_idx));
    chk("off_dir", direcao, pp_dir(m_idx));
    chk("off_aval", ameaca_valida, m_av);
  endtask

  initial begin
    bit f;
    reset = 1; ligar = 0; girar = 0; pronto_ciclo = 0;
    timeout_medicao = 0; ameaca_detectada = 0;
    repeat (3) tick();
    chk("rst_estado", db_estado, 0);
    chk("rst_lt", ligar_torreta, 0);
    chk("rst_pos", posicao, 0);
    chk("rst_dir", direcao, 0);
    chk("rst_falha", falha, 0);
    chk("rst_aval", ameaca_valida, 0);
    chk("rst_apos", ameaca_posicao, 0);
    reset = 0;
    repeat (6) tick();

    // start-up and a clean 7-step ping-pong sweep, threat seen at position 2
    start_sweep();
    for (int i = 0; i < 7; i++) begin
      step(0, 0, (m_idx == 2), f);
    end
    chk("threat_pos", ameaca_posicao, 2);

    // two timeouts, a clean cycle, two more: the run is broken, no fault
    step(0, 1, 0, f); step(0, 1, 0, f); step(0, 0, 0, f);
    step(0, 1, 0, f); step(0, 1, 0, f);
    chk("clear_nofault", f, 0);

    // three consecutive timed-out cycles: fault on the third timeout
    step(0, 0, 0, f);
    step(0, 1, 0, f); step(0, 1, 0, f); step(0, 1, 0, f);
    chk("fault_seen", f, 1);
    disable_sweep();

    // abort while waiting for the servo to settle
    ligar = 1;
    tick();
    tick();
    chk("abort_wait_estado", db_estado, 1);
    disable_sweep();

    // reset while in CICLO
    start_sweep();
    step(0, 0, 1, f);
    reset = 1;
    tick();
    reset = 0; ligar = 0;
    m_idx = 0; m_cnt = 0; m_teve = 0; m_ap = 0; m_av = 0;
    chk("rstc_estado", db_estado, 0);
    chk("rstc_pos", posicao, 0);
    chk("rstc_dir", direcao, 0);
    chk("rstc_lt", ligar_torreta, 0);
    chk("rstc_aval", ameaca_valida, 0);
    chk("rstc_apos", ameaca_posicao, 0);
    tick();

    // randomized sweep with timeouts, fixar-mode prontos and threats
    start_sweep();
    for (int i = 0; i < 60; i++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 3) == 0, f);
      if (f) begin
        disable_sweep();
        start_sweep();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
